// File: rtl/multicycle_ctrl_if.sv
// Request/acknowledge handshake between the sequencer
// and the shared instruction/data memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over a
// shared memory with wait states, halt parking and retire counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             cond,
  input  logic             halt,
  multicycle_ctrl_if.master mem,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             irWrite,
  output logic             regDst,
  output logic             aluSrc,
  output logic             memtoReg,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic [3:0]       aluOp,
  output logic             idle,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_B     = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BSWAP = 6'b011111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_BS,
    CLS_LW,
    CLS_SW,
    CLS_IMM,
    CLS_BR,
    CLS_J,
    CLS_ILL
  } cls_t;

  state_t state;
  state_t nextState;
  state_t endState;
  cls_t   cls;
  logic [3:0] decAlu;
  logic   decImm;
  logic   memAck;
  logic   retireEv;
  logic   illegalEv;

  assign memAck = mem.mem_ready;

  // Opcode classification and per-class ALU setup
  always_comb begin
    cls    = CLS_ILL;
    decAlu = 4'b0000;
    decImm = 1'b0;
    case (opcode)
      OP_R: begin
        cls    = CLS_R;
        decAlu = 4'b0010;
      end
      OP_BSWAP: begin
        cls    = CLS_BS;
        decAlu = 4'b1111;
      end
      OP_LW: begin
        cls    = CLS_LW;
        decImm = 1'b1;
      end
      OP_SW: begin
        cls    = CLS_SW;
        decImm = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        cls    = CLS_IMM;
        decImm = 1'b1;
      end
      OP_ANDI: begin
        cls    = CLS_IMM;
        decAlu = 4'b0100;
        decImm = 1'b1;
      end
      OP_ORI: begin
        cls    = CLS_IMM;
        decAlu = 4'b0101;
        decImm = 1'b1;
      end
      OP_XORI: begin
        cls    = CLS_IMM;
        decAlu = 4'b0111;
        decImm = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        cls    = CLS_IMM;
        decAlu = 4'b0110;
        decImm = 1'b1;
      end
      OP_LUI: begin
        cls    = CLS_IMM;
        decAlu = 4'b1001;
        decImm = 1'b1;
      end
      OP_BEQ: begin
        cls    = CLS_BR;
        decAlu = 4'b0001;
      end
      OP_BNE: begin
        cls    = CLS_BR;
        decAlu = 4'b1011;
      end
      OP_BGEZ: begin
        cls    = CLS_BR;
        decAlu = 4'b0011;
      end
      OP_B: begin
        cls    = CLS_BR;
        decAlu = 4'b1000;
      end
      OP_J: begin
        cls    = CLS_J;
      end
      default: begin
        cls    = CLS_ILL;
      end
    endcase
  end

  // Instruction-boundary events; halt is only honoured on these
  always_comb begin
    retireEv  = 1'b0;
    illegalEv = 1'b0;
    unique case (1'b1)
      (state == DECODE): begin
        retireEv  = (cls == CLS_J);
        illegalEv = (cls == CLS_ILL);
      end
      (state == EXEC):
        retireEv = (cls == CLS_BR);
      (state == MEM):
        retireEv = (cls == CLS_SW) && memAck;
      (state == WB):
        retireEv = 1'b1;
      default: begin
        retireEv  = 1'b0;
        illegalEv = 1'b0;
      end
    endcase
  end

  assign endState = halt ? IDLE : FETCH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (!halt) nextState = FETCH;
      end
      FETCH: begin
        if (memAck) nextState = DECODE;
      end
      DECODE: begin
        if (cls == CLS_J || cls == CLS_ILL) begin
          nextState = endState;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        if (cls == CLS_BR) begin
          nextState = endState;
        end else if (cls == CLS_LW || cls == CLS_SW) begin
          nextState = MEM;
        end else begin
          nextState = WB;
        end
      end
      MEM: begin
        if (memAck) begin
          if (cls == CLS_SW) begin
            nextState = endState;
          end else begin
            nextState = WB;
          end
        end
      end
      WB: begin
        nextState = endState;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_sel = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = 2'd0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    aluSrc      = 1'b0;
    memtoReg    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    aluOp       = 4'b0000;
    idle        = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
      end
      FETCH: begin
        mem.mem_req = 1'b1;
        memRead     = 1'b1;
        irWrite     = memAck;
        pcWrite     = memAck;
      end
      DECODE: begin
        if (cls == CLS_J) begin
          pcWrite = 1'b1;
          pcSrc   = 2'd2;
        end
      end
      EXEC: begin
        aluOp  = decAlu;
        aluSrc = decImm;
        if (cls == CLS_BR) begin
          pcWrite = cond;
          pcSrc   = 2'd1;
        end
      end
      MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_sel = 1'b1;
        memRead     = (cls == CLS_LW);
        memWrite    = (cls == CLS_SW);
      end
      WB: begin
        regWrite = 1'b1;
        regDst   = (cls == CLS_R) || (cls == CLS_BS);
        memtoReg = (cls == CLS_LW);
      end
      default: begin
        idle = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
    end else if (illegalEv) begin
      illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retireEv) begin
      instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random instruction stream with memory wait states and halts;
// a monitor folds each instruction's cycles and checks a queued model.
module tb_multicycle_ctrl;

  localparam int W = 4;
  localparam int N = 80;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   opcode;
  logic         cond;
  logic         halt;
  logic         pcWrite;
  logic [1:0]   pcSrc;
  logic         irWrite;
  logic         regDst;
  logic         aluSrc;
  logic         memtoReg;
  logic         memRead;
  logic         memWrite;
  logic         regWrite;
  logic [3:0]   aluOp;
  logic         idle;
  logic         illegal;
  logic [W-1:0] instret;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.CNT_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .cond     (cond),
    .halt     (halt),
    .mem      (bus),
    .pcWrite  (pcWrite),
    .pcSrc    (pcSrc),
    .irWrite  (irWrite),
    .regDst   (regDst),
    .aluSrc   (aluSrc),
    .memtoReg (memtoReg),
    .memRead  (memRead),
    .memWrite (memWrite),
    .regWrite (regWrite),
    .aluOp    (aluOp),
    .idle     (idle),
    .illegal  (illegal),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  typedef enum {K_R, K_BS, K_LW, K_SW, K_IMM, K_BR, K_J, K_ILL} kind_e;

  typedef struct packed {
    int cyc;
    int iRd;
    int dRd;
    int dWr;
    int irW;
    int pc4;
    int brT;
    int jmp;
    int rw;
    logic [1:0] src;
    logic [3:0] alu;
    logic aSrc;
    logic rd;
    logic mtr;
    logic ill;
    logic [W-1:0] ins;
  } rec_t;

  int errors = 0;
  int checks = 0;
  rec_t expQ[$];
  logic [5:0] opQ[$];
  bit monEn = 1'b0;
  bit recOpen = 1'b0;
  bit prevF = 1'b0;
  rec_t cur;

  function automatic kind_e kindOf(logic [5:0] op);
    case (op)
      6'h00: return K_R;
      6'h1f: return K_BS;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e, 6'h0f: return K_IMM;
      6'h01, 6'h03, 6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] aluOf(logic [5:0] op);
    case (op)
      6'h00: return 4'b0010;
      6'h0c: return 4'b0100;
      6'h0d: return 4'b0101;
      6'h0e: return 4'b0111;
      6'h0a, 6'h0b: return 4'b0110;
      6'h0f: return 4'b1001;
      6'h1f: return 4'b1111;
      6'h04: return 4'b0001;
      6'h05: return 4'b1011;
      6'h01: return 4'b0011;
      6'h03: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic rec_t model(logic [5:0] op, bit c, int fw, int mw);
    kind_e k;
    rec_t e;
    k = kindOf(op);
    e = '0;
    e.iRd = fw + 1;
    e.irW = 1;
    e.pc4 = 1;
    case (k)
      K_J, K_ILL: e.cyc = fw + 2;
      K_BR:       e.cyc = fw + 3;
      K_LW:       e.cyc = fw + 5 + mw;
      K_SW:       e.cyc = fw + 4 + mw;
      default:    e.cyc = fw + 4;
    endcase
    if (k != K_J && k != K_ILL) e.alu = aluOf(op);
    e.aSrc = (k == K_LW || k == K_SW || k == K_IMM);
    e.rw   = (k == K_R || k == K_BS || k == K_LW || k == K_IMM) ? 1 : 0;
    e.rd   = (k == K_R || k == K_BS);
    e.mtr  = (k == K_LW);
    e.dRd  = (k == K_LW) ? mw + 1 : 0;
    e.dWr  = (k == K_SW) ? mw + 1 : 0;
    e.brT  = (k == K_BR && c) ? 1 : 0;
    e.jmp  = (k == K_J) ? 1 : 0;
    e.src  = (k == K_BR) ? 2'd1 : (k == K_J) ? 2'd2 : 2'd0;
    return e;
  endfunction

  function automatic string fmt(rec_t r);
    return $sformatf(
      "cyc=%0d iRd=%0d dRd=%0d dWr=%0d irW=%0d pc4=%0d brT=%0d jmp=%0d rw=%0d src=%0d alu=%b aSrc=%0d rd=%0d mtr=%0d ill=%0d ins=%0d",
      r.cyc, r.iRd, r.dRd, r.dWr, r.irW, r.pc4, r.brT, r.jmp, r.rw,
      r.src, r.alu, r.aSrc, r.rd, r.mtr, r.ill, r.ins);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic closeRec();
    rec_t e;
    logic [5:0] op;
    cur.ins = instret;
    cur.ill = illegal;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL instr: unexpected instruction got %s", fmt(cur));
    end else begin
      e  = expQ.pop_front();
      op = opQ.pop_front();
      if (cur != e) begin
        errors++;
        $display("FAIL instr op=%b: got %s want %s", op, fmt(cur), fmt(e));
      end
    end
    recOpen = 1'b0;
  endtask

  always @(negedge clk) begin
    bit fNow;
    bit start;
    if (monEn) begin
      fNow  = bus.mem_req && !bus.mem_sel;
      start = fNow && !prevF;
      if (recOpen && (start || idle)) closeRec();
      if (start) begin
        cur = '0;
        recOpen = 1'b1;
      end
      if (recOpen) begin
        cur.cyc++;
        if (memRead && !bus.mem_sel) cur.iRd++;
        if (memRead && bus.mem_sel) cur.dRd++;
        if (memWrite) cur.dWr++;
        if (irWrite) cur.irW++;
        if (pcWrite && pcSrc == 2'd0) cur.pc4++;
        if (pcWrite && pcSrc == 2'd1) cur.brT++;
        if (pcWrite && pcSrc == 2'd2) cur.jmp++;
        if (regWrite) cur.rw++;
        cur.src  |= pcSrc;
        cur.alu  |= aluOp;
        cur.aSrc |= aluSrc;
        cur.rd   |= regDst;
        cur.mtr  |= memtoReg;
      end
      prevF = fNow;
    end
  end

  task automatic doReq(int waits);
    bus.mem_ready = 1'b0;
    repeat (waits) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic waitSig(int which, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 20) begin
      if (which == 0 && bus.mem_req && !bus.mem_sel) ok = 1'b1;
      if (which == 1 && bus.mem_req && bus.mem_sel) ok = 1'b1;
      if (which == 2 && idle) ok = 1'b1;
      if (ok) break;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: waiting for event %0d got none want seen", which);
    end
  endtask

  logic [5:0] known [17] = '{
    6'h00, 6'h1f, 6'h23, 6'h2b, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
    6'h0d, 6'h0e, 6'h0f, 6'h01, 6'h03, 6'h04, 6'h05, 6'h02
  };

  initial begin
    bit ok;
    bit abort;
    bit illSeen;
    int retired;
    logic [5:0] op;
    bit c;
    bit h;
    int fw;
    int mw;
    rec_t e;
    kind_e k;

    abort = 1'b0;
    illSeen = 1'b0;
    retired = 0;
    reset = 1'b1;
    halt = 1'b1;
    opcode = 6'd0;
    cond = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({bus.mem_req, bus.mem_sel, pcWrite, pcSrc,
        irWrite, regDst, aluSrc, memtoReg, memRead, memWrite,
        regWrite, aluOp}), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("parked_idle", 32'(idle), 32'd1);
    monEn = 1'b1;
    @(posedge clk);
    #1;
    halt = 1'b0;

    for (int i = 0; i < N; i++) begin
      waitSig(0, ok);
      if (!ok) begin
        abort = 1'b1;
        break;
      end
      if (i == 5) begin
        op = 6'h3f;
      end else if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (kindOf(op) != K_ILL) op = 6'($urandom_range(0, 63));
      end else begin
        op = known[$urandom_range(0, 16)];
      end
      k  = kindOf(op);
      c  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      h  = (i == N - 1) || ($urandom_range(0, 7) == 0);
      if (k == K_ILL) illSeen = 1'b1;
      else retired++;
      e = model(op, c, fw, mw);
      e.ins = W'(retired);
      e.ill = illSeen;
      expQ.push_back(e);
      opQ.push_back(op);
      opcode = op;
      cond = c;
      halt = h;
      doReq(fw);
      if (k == K_LW || k == K_SW) begin
        waitSig(1, ok);
        if (!ok) begin
          abort = 1'b1;
          break;
        end
        doReq(mw);
      end
      if (h) begin
        waitSig(2, ok);
        if (!ok) begin
          abort = 1'b1;
          break;
        end
        if (i < N - 1) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          halt = 1'b0;
          @(posedge clk);
          #1;
          chk("resume_fetch", 32'(bus.mem_req && !bus.mem_sel), 32'd1);
        end
      end
    end

    if (!abort) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(expQ.size()), 32'd0);
      chk("halt_parked", 32'(idle), 32'd1);
      monEn = 1'b0;
      @(posedge clk);
      #1;
      halt = 1'b0;
      waitSig(0, ok);
      if (ok) begin
        opcode = 6'h2b;
        doReq(0);
        waitSig(1, ok);
        if (ok) begin
          @(negedge clk);
          chk("sw_mem_write", 32'({memWrite, bus.mem_req}), 32'd3);
          chk("sticky_illegal", 32'(illegal), 32'd1);
          #2;
          reset = 1'b1;
          halt = 1'b1;
          #1;
          chk("abort_ctrl", 32'({bus.mem_req, memWrite, memRead,
              regWrite, pcWrite, irWrite}), 32'd0);
          chk("abort_idle", 32'(idle), 32'd1);
          chk("abort_instret", 32'(instret), 32'd0);
          chk("abort_illegal", 32'(illegal), 32'd0);
          @(posedge clk);
          #1;
          reset = 1'b0;
          @(negedge clk);
          chk("post_abort_idle", 32'(idle), 32'd1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a state machine that spreads each instruction over FETCH/DECODE/EXEC/MEM/WB cycles. Its handshake with a shared instruction/data memory tolerates wait states. It drives the same control signals the datapath muxes, ALU control and register file already consume, and adds PC/IR write enables, a halt/idle mechanism and a retired-instruction counter.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward
- cond  in  1  ALU branch-condition result (taken when 1), valid in EXEC
- mem_ready  in  1  memory completes the current request when high at a rising edge
- halt  in  1  request to stop at the next instruction boundary
- mem_req  out  1  memory request (FETCH or MEM)
- mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result)
- pcWrite  out  1  PC register enable
- pcSrc  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- irWrite  out  1  instruction register enable
- regDst, aluSrc, memtoReg, memRead, memWrite, regWrite  out  1 each  same meaning as datapath control
- aluOp  out  4  ALU control code
- idle  out  1  FSM parked in IDLE
- illegal  out  1  sticky: unknown opcode decoded
- instret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. All outputs are decoded combinationally from the state and the opcode. Every output is 0 unless it is listed as asserted for the current state.
- IDLE: idle=1. Go to FETCH when halt=0.
- FETCH: mem_req=1, mem_sel=0, memRead=1. Hold until mem_ready=1. On that edge: irWrite=1, pcWrite=1, pcSrc=0, then go to DECODE.
- DECODE: classify the opcode.
  - Jump (000010): pcWrite=1, pcSrc=2, retire, go to FETCH.
  - Unknown opcode: set illegal, do not retire, go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC, aluOp per class: R-type 000000 -> 0010; lw 100011, sw 101011, addi 001000, addiu 001001 -> 0000; andi -> 0100; ori -> 0101; xori -> 0111; slti/sltiu -> 0110; lui 001111 -> 1001; bitswap 011111 -> 1111; beq -> 0001; bne -> 1011; bgez 000001 -> 0011; b 000011 -> 1000.
- EXEC, aluSrc: 1 for immediate, load and store classes; 0 for R-type, bitswap and branches.
- EXEC, branch class: pcWrite=cond, pcSrc=1, retire, go to FETCH.
- EXEC, other classes: lw/sw go to MEM; all others go to WB.
- MEM: mem_req=1, mem_sel=1. memRead=1 for lw, memWrite=1 for sw; the enable is held stable until mem_ready. On mem_ready, sw retires and goes to FETCH; lw goes to WB.
- WB: regWrite=1. regDst=1 for R-type and bitswap. memtoReg=1 for lw. Retire, go to FETCH.
- Retire: instret increments by 1 and wraps modulo 2^CNT_W.
- Halt: halt is sampled only on the retire edge or the illegal-opcode edge. If halt=1 on that edge, the next state is IDLE instead of FETCH. An instruction in flight always completes.

## Timing
- Reset (async, immediate) puts the FSM in IDLE, clears illegal and clears instret. All control outputs are 0, idle=1.
- mem_ready is sampled only while mem_req=1. A request is never withdrawn before completion. mem_req drops in the cycle after mem_ready is accepted.
- Cycle counts with zero wait states:
  - jump: 2
  - branch: 3
  - R-type and immediate ops: 4
  - sw: 4
  - lw: 5
- Each memory wait cycle adds exactly 1 cycle.
- Reset asserted mid-instruction aborts it at once: no retire, no write enable left high.

## Test plan
- Reset, then halt=0, mem_ready=1 always, opcode=000000 -> states IDLE, FETCH, DECODE, EXEC, WB. regWrite=1 and regDst=1 in WB only, aluOp=0010 in EXEC, instret=1 after 4 cycles.
- lw (100011) with mem_ready low for 3 cycles in MEM -> memRead and mem_sel=1 held for 4 cycles, then WB with memtoReg=1. 8 cycles total, instret +1.
- beq (000100) with cond=0, then again with cond=1 -> pcWrite=0 in EXEC for the first, pcWrite=1 with pcSrc=1 for the second. Each takes 3 cycles, instret +2.
- Jump (000010), then an unknown opcode 111111 -> the jump retires in DECODE with pcSrc=2. The unknown opcode sets illegal=1, which stays 1, and instret is unchanged.
- halt raised during EXEC of an addi -> WB completes, the FSM goes to IDLE, idle=1, instret +1. Dropping halt resumes FETCH the next cycle.
- Reset pulsed during MEM of an sw -> memWrite and mem_req go to 0 immediately, the FSM returns to IDLE, and instret and illegal are both 0.
